// File: rtl/mips_stage_pc_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_stage_pc_fetch                                                  |
// | Fetch stage: owns the PC, issues one-outstanding imem requests, has  |
// | a one-entry hold buffer for stalls and applies branch/jump redirects.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mips_stage_pc_fetch #(
  parameter bit          DELAYED    = 1'b1,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirectValid,
  input  logic [31:0] redirectAddr,
  output logic        imemReqValid,
  output logic [31:0] imemReqAddr,
  input  logic        imemReqReady,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic        outValid,
  output logic [31:0] outInstruction,
  output logic [31:0] outPcAddr
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_FULL = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_q, inflight_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        squash_q, squash_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;

  logic        redirect_kill;
  logic [31:0] redirect_pc;

  // Without a delay slot, a redirect kills whatever is in flight or held.
  assign redirect_kill = !DELAYED && redirectValid;
  assign redirect_pc   = redirectAddr & 32'hFFFF_FFFC;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_ADDR;
      inflight_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP;
      hold_pc_q    <= '0;
      squash_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= NOP;
      out_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      squash_q     <= squash_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    squash_d     = squash_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;

    if (!stall) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP;
      out_pc_d    = '0;
    end

    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        if (imemReqReady) begin
          inflight_d = pc_q;
          pc_d       = pc_q + 32'd4;
          squash_d   = redirect_kill;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imemRespValid) begin
          state_d = ST_REQ;
          // A kill landing with the response drops it directly rather than
          // arming the flag against the next fetch.
          if (squash_q || redirect_kill) begin
            squash_d = 1'b0;
          end else if (!stall && !hold_valid_q) begin
            out_valid_d = 1'b1;
            out_instr_d = imemRespData;
            out_pc_d    = inflight_q;
          end else begin
            hold_valid_d = 1'b1;
            hold_instr_d = imemRespData;
            hold_pc_d    = inflight_q;
            state_d      = ST_FULL;
          end
        end else if (redirect_kill) begin
          squash_d = 1'b1;
        end
      end
      ST_FULL: begin
        if (redirect_kill || !stall) begin
          state_d      = ST_REQ;
          hold_valid_d = 1'b0;
          if (!redirect_kill) begin
            out_valid_d = 1'b1;
            out_instr_d = hold_instr_q;
            out_pc_d    = hold_pc_q;
          end
        end
      end
      default: state_d = ST_BOOT;
    endcase

    if (redirectValid) begin
      pc_d = redirect_pc;
    end

    if (redirect_kill && !stall) begin
      out_valid_d = 1'b0;
      out_instr_d = NOP;
      out_pc_d    = '0;
    end
  end

  assign imemReqValid   = (state_q == ST_REQ);
  assign imemReqAddr    = pc_q;
  assign outValid       = out_valid_q;
  assign outInstruction = out_instr_q;
  assign outPcAddr      = out_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_stage_pc_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mips_stage_pc_fetch                                               |
// | Bench driving a delay-slot and a squashing instance side by side.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mips_stage_pc_fetch;

  localparam logic [31:0] NOP1 = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir_v = 1'b0;
  logic [31:0] redir_a = '0;
  logic [1:0]  ready = '0;
  logic [1:0]  resp_v = '0;
  logic [31:0] resp_d [2];
  logic [1:0]  req_v;
  logic [31:0] req_a [2];
  logic [1:0]  out_v;
  logic [31:0] out_i [2];
  logic [31:0] out_p [2];

  always #5 clk = ~clk;

  mips_stage_pc_fetch #(.DELAYED(1'b1), .RESET_ADDR(32'h0), .NOP(32'h0)) u_dly (
    .clock(clk), .reset(rst), .stall(stall),
    .redirectValid(redir_v), .redirectAddr(redir_a),
    .imemReqValid(req_v[0]), .imemReqAddr(req_a[0]), .imemReqReady(ready[0]),
    .imemRespValid(resp_v[0]), .imemRespData(resp_d[0]),
    .outValid(out_v[0]), .outInstruction(out_i[0]), .outPcAddr(out_p[0])
  );

  mips_stage_pc_fetch #(.DELAYED(1'b0), .RESET_ADDR(32'h0), .NOP(NOP1)) u_sq (
    .clock(clk), .reset(rst), .stall(stall),
    .redirectValid(redir_v), .redirectAddr(redir_a),
    .imemReqValid(req_v[1]), .imemReqAddr(req_a[1]), .imemReqReady(ready[1]),
    .imemRespValid(resp_v[1]), .imemRespData(resp_d[1]),
    .outValid(out_v[1]), .outInstruction(out_i[1]), .outPcAddr(out_p[1])
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Transaction-level reference: expected PC, one outstanding memory
  // request, at most one pending undelivered word, and the output register.
  logic [31:0] c_nop [2];
  bit          m_boot [2];
  logic [31:0] m_pc [2];
  bit          m_out_v [2];
  logic [31:0] m_out_i [2];
  logic [31:0] m_out_p [2];
  bit          m_pend_v [2];
  logic [31:0] m_pend_i [2];
  logic [31:0] m_pend_p [2];
  bit          m_os [2];
  logic [31:0] m_os_addr [2];
  bit          m_os_sq [2];
  int          m_os_cnt [2];

  int  lat_fixed  = 2;
  bit  rand_mode  = 0;
  bit  spur_force = 0;
  bit  log_en     = 0;
  bit  last_stall = 0;
  logic [31:0] dq0[$], dq1[$], aq0[$], aq1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic string tg(input string s, input int d);
    return $sformatf("%s[%0d]", s, d);
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_boot[d] = 1; m_pc[d] = 32'h0;
      m_out_v[d] = 0; m_out_i[d] = c_nop[d]; m_out_p[d] = 32'h0;
      m_pend_v[d] = 0; m_os[d] = 0; m_os_sq[d] = 0; m_os_cnt[d] = 0;
    end
  endtask

  task automatic chk_reset_vals();
    for (int d = 0; d < 2; d++) begin
      chk(tg("rst_req_valid", d), {31'b0, req_v[d]}, 32'h0);
      chk(tg("rst_out_valid", d), {31'b0, out_v[d]}, 32'h0);
      chk(tg("rst_out_instr", d), out_i[d], c_nop[d]);
      chk(tg("rst_out_pc", d), out_p[d], 32'h0);
    end
  endtask

  // One clock: check outputs against the model, drive memory, advance model.
  task automatic cycle();
    bit er [2];
    bit acc, rr, kill;
    logic [31:0] wi, wp;
    for (int d = 0; d < 2; d++) begin
      er[d] = !m_boot[d] && !m_os[d] && !m_pend_v[d];
      chk(tg("req_valid", d), {31'b0, req_v[d]}, {31'b0, er[d]});
      if (er[d]) chk(tg("req_addr", d), req_a[d], m_pc[d]);
      chk(tg("out_valid", d), {31'b0, out_v[d]}, {31'b0, m_out_v[d]});
      chk(tg("out_instr", d), out_i[d], m_out_i[d]);
      chk(tg("out_pc", d), out_p[d], m_out_p[d]);
      if (log_en && out_v[d] && !last_stall) begin
        if (d == 0) dq0.push_back(out_p[d]); else dq1.push_back(out_p[d]);
      end
      if (m_os[d]) begin
        resp_v[d] = (m_os_cnt[d] == 1);
        resp_d[d] = m_os_addr[d] ^ 32'hA5A5_0000;
      end else begin
        resp_v[d] = spur_force || (rand_mode && $urandom_range(0, 9) == 0);
        resp_d[d] = $urandom;
      end
    end
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        acc  = er[d] && ready[d];
        rr   = m_os[d] && resp_v[d];
        kill = (d == 1) && redir_v;
        wi   = resp_d[d];
        wp   = m_os_addr[d];
        if (log_en && acc) begin
          if (d == 0) aq0.push_back(m_pc[d]); else aq1.push_back(m_pc[d]);
        end
        if (kill) begin
          m_pend_v[d] = 0;
          if (!stall) begin m_out_v[d] = 0; m_out_i[d] = c_nop[d]; m_out_p[d] = 0; end
        end else if (!stall) begin
          if (m_pend_v[d]) begin
            m_out_v[d] = 1; m_out_i[d] = m_pend_i[d]; m_out_p[d] = m_pend_p[d];
            m_pend_v[d] = 0;
          end else if (rr && !m_os_sq[d]) begin
            m_out_v[d] = 1; m_out_i[d] = wi; m_out_p[d] = wp;
          end else begin
            m_out_v[d] = 0; m_out_i[d] = c_nop[d]; m_out_p[d] = 0;
          end
        end else if (rr && !m_os_sq[d]) begin
          m_pend_v[d] = 1; m_pend_i[d] = wi; m_pend_p[d] = wp;
        end
        if (rr) m_os[d] = 0;
        else if (m_os[d]) begin
          m_os_cnt[d]--;
          if (kill) m_os_sq[d] = 1;
        end
        if (acc) begin
          m_os[d] = 1; m_os_addr[d] = m_pc[d]; m_os_sq[d] = kill;
          m_os_cnt[d] = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3);
        end
        if (redir_v) m_pc[d] = redir_a & 32'hFFFF_FFFC;
        else if (acc) m_pc[d] = m_pc[d] + 32'd4;
        m_boot[d] = 0;
      end
    end
    last_stall = stall;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap_p, snap_i, pa;
    bit snap_v, hit;
    c_nop[0] = 32'h0;
    c_nop[1] = NOP1;
    resp_d[0] = '0;
    resp_d[1] = '0;
    model_reset();
    @(negedge clk);
    chk_reset_vals();
    cycle();

    // Streaming fetch, then a redirect to 0x103 while 0x8 is in flight.
    rst = 1'b0; ready = 2'b11; log_en = 1;
    hit = 0;
    for (int k = 0; k < 60 && !hit; k++) begin
      hit = m_os[0] && m_os_addr[0] == 32'h8 && m_os_cnt[0] == 2;
      if (!hit) cycle();
    end
    chk("reach_wait_8", {31'b0, hit}, 32'h1);
    redir_v = 1'b1; redir_a = 32'h0000_0103;
    cycle();
    redir_v = 1'b0;
    repeat (14) cycle();
    chk("dly_out0", qget(dq0, 0), 32'h0);
    chk("dly_out1", qget(dq0, 1), 32'h4);
    chk("dly_out2_slot", qget(dq0, 2), 32'h8);
    chk("dly_out3", qget(dq0, 3), 32'h100);
    chk("dly_req3", qget(aq0, 3), 32'h100);
    chk("sq_out2", qget(dq1, 2), 32'h100);
    chk("sq_req3", qget(aq1, 3), 32'h100);
    log_en = 0;

    // Six-cycle stall: output frozen, response parked, no request.
    repeat (3) cycle();
    snap_p = m_out_p[0]; snap_i = m_out_i[0]; snap_v = m_out_v[0];
    stall = 1'b1;
    repeat (6) cycle();
    chk("stall_hold_pc", out_p[0], snap_p);
    chk("stall_hold_instr", out_i[0], snap_i);
    chk("stall_hold_valid", {31'b0, out_v[0]}, {31'b0, snap_v});
    chk("stall_no_req", {31'b0, req_v[0]}, 32'h0);
    stall = 1'b0;
    repeat (6) cycle();

    // Memory not ready for four cycles: address held.
    ready = 2'b00;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      hit = !m_boot[0] && !m_os[0] && !m_pend_v[0];
      if (!hit) cycle();
    end
    chk("reach_req", {31'b0, hit}, 32'h1);
    pa = m_pc[0];
    repeat (4) begin
      cycle();
      chk("notready_addr", req_a[0], pa);
    end
    ready = 2'b11;

    // Reset while waiting, then a stale response after release.
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      hit = m_os[0];
      if (!hit) cycle();
    end
    chk("reach_wait_rst", {31'b0, hit}, 32'h1);
    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_vals();
    cycle();
    cycle();
    rst = 1'b0; spur_force = 1; log_en = 1;
    dq0.delete(); dq1.delete(); aq0.delete(); aq1.delete();
    cycle();
    cycle();
    spur_force = 0;
    repeat (10) cycle();
    chk("rst_first_out_d0", qget(dq0, 0), 32'h0);
    chk("rst_first_out_d1", qget(dq1, 0), 32'h0);
    chk("rst_first_req", qget(aq0, 0), 32'h0);

    // PC wrap from the top of the address space.
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      hit = m_os[0];
      if (!hit) cycle();
    end
    chk("reach_wait_wrap", {31'b0, hit}, 32'h1);
    aq0.delete(); aq1.delete();
    redir_v = 1'b1; redir_a = 32'hFFFF_FFFC;
    cycle();
    redir_v = 1'b0;
    repeat (12) cycle();
    chk("wrap_req0_d0", qget(aq0, 0), 32'hFFFF_FFFC);
    chk("wrap_req1_d0", qget(aq0, 1), 32'h0);
    chk("wrap_req0_d1", qget(aq1, 0), 32'hFFFF_FFFC);
    chk("wrap_req1_d1", qget(aq1, 1), 32'h0);
    log_en = 0;

    // Randomized traffic against the reference model.
    lat_fixed = 0; rand_mode = 1;
    repeat (3000) begin
      stall   = ($urandom_range(0, 9) < 3);
      redir_v = ($urandom_range(0, 99) < 4);
      redir_a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      ready   = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      cycle();
    end
    stall = 1'b0; redir_v = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
